// File: rtl/ir_blob_decoder_pkg.sv
// Camera-domain constants and FSM encoding shared by the IR blob decoder
// and any future tracker that consumes extended-mode reports.
package ir_blob_decoder_pkg;

    localparam int CAM_W          = 1024;
    localparam int CAM_H          = 768;
    localparam int BYTES_PER_BLOB = 3;

    localparam logic [9:0] NO_BLOB = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_BLOB,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ir_blob_unpack.sv
// Combinational unpacker: one 3-byte extended-mode blob slot into x/y/size
// plus a flag saying whether the slot holds a real blob.
module ir_blob_unpack
    import ir_blob_decoder_pkg::*;
(
    input  logic [7:0] xl,
    input  logic [7:0] yl,
    input  logic [7:0] hi,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [3:0] size,
    output logic       blob_ok
);

    // An all-0xFF slot decodes to 1023 on a coordinate, which the camera
    // uses to mean "no blob here".
    always_comb begin
        x       = {hi[5:4], xl};
        y       = {hi[7:6], yl};
        size    = hi[3:0];
        blob_ok = (x != NO_BLOB) && (y != NO_BLOB);
    end

endmodule

// File: rtl/ir_blob_decoder.sv
// Parses one IR camera report per frame_start and publishes the first valid
// blob's coordinates with a one-cycle valid pulse; aborts stalled frames.
module ir_blob_decoder
    import ir_blob_decoder_pkg::*;
#(
    parameter int NUM_BLOBS      = 4,
    parameter int HEADER_BYTES   = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [3:0] size,
    output logic       blob_found,
    output logic       valid,
    output logic       error
);

    localparam int HDR_W = (HEADER_BYTES > 0) ? $clog2(HEADER_BYTES + 1) : 1;
    localparam int BI_W  = $clog2(NUM_BLOBS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [HDR_W-1:0] HDR_LAST  = HDR_W'((HEADER_BYTES > 0) ? HEADER_BYTES - 1 : 0);
    localparam logic [BI_W-1:0]  BLOB_LAST = BI_W'(NUM_BLOBS - 1);
    localparam logic [1:0]       BYTE_LAST = 2'(BYTES_PER_BLOB - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam state_t           FIRST_ST  = (HEADER_BYTES > 0) ? ST_HEADER : ST_BLOB;

    state_t state, state_n;

    logic [HDR_W-1:0] hdr_cnt;
    logic [1:0]       byte_idx;
    logic [BI_W-1:0]  blob_idx;
    logic [TO_W-1:0]  idle_cnt;
    logic [7:0]       xl, yl;

    logic       cand_valid;
    logic [9:0] cand_x, cand_y;
    logic [3:0] cand_size;

    logic [9:0] unp_x, unp_y;
    logic [3:0] unp_size;
    logic       unp_ok;

    logic in_frame, timeout_hit, blob_done, frame_end;

    ir_blob_unpack u_unpack (
        .xl      (xl),
        .yl      (yl),
        .hi      (data),
        .x       (unp_x),
        .y       (unp_y),
        .size    (unp_size),
        .blob_ok (unp_ok)
    );

    always_comb begin
        in_frame    = (state == ST_HEADER) || (state == ST_BLOB);
        timeout_hit = in_frame && !data_valid && (idle_cnt == TO_LAST);
        blob_done   = (state == ST_BLOB) && data_valid && (byte_idx == BYTE_LAST);
        frame_end   = blob_done && (blob_idx == BLOB_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // frame_start restarts from any state, so a coincident byte is dropped.
    always_comb begin
        state_n = state;
        if (frame_start) begin
            state_n = FIRST_ST;
        end else begin
            case (state)
                ST_IDLE:   state_n = ST_IDLE;
                ST_HEADER: begin
                    if (data_valid && hdr_cnt == HDR_LAST) state_n = ST_BLOB;
                    else if (timeout_hit)                  state_n = ST_IDLE;
                end
                ST_BLOB: begin
                    if (frame_end)        state_n = ST_DONE;
                    else if (timeout_hit) state_n = ST_IDLE;
                end
                ST_DONE:   state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs are loaded on the edge that accepts the final byte, so valid and
    // the new coordinates appear together in the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt    <= '0;
            byte_idx   <= '0;
            blob_idx   <= '0;
            idle_cnt   <= '0;
            xl         <= '0;
            yl         <= '0;
            cand_valid <= 1'b0;
            cand_x     <= '0;
            cand_y     <= '0;
            cand_size  <= '0;
            x          <= '0;
            y          <= '0;
            size       <= '0;
            blob_found <= 1'b0;
            valid      <= 1'b0;
            error      <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (frame_start) begin
                hdr_cnt    <= '0;
                byte_idx   <= '0;
                blob_idx   <= '0;
                idle_cnt   <= '0;
                cand_valid <= 1'b0;
            end else begin
                if (!in_frame || data_valid) idle_cnt <= '0;
                else if (timeout_hit)        idle_cnt <= '0;
                else                         idle_cnt <= idle_cnt + 1'b1;

                if (timeout_hit) error <= 1'b1;

                if (state == ST_HEADER && data_valid) hdr_cnt <= hdr_cnt + 1'b1;

                if (state == ST_BLOB && data_valid) begin
                    case (byte_idx)
                        2'd0:    xl <= data;
                        2'd1:    yl <= data;
                        default: ;
                    endcase
                    if (blob_done) begin
                        byte_idx <= '0;
                        blob_idx <= blob_idx + 1'b1;
                        if (unp_ok && !cand_valid) begin
                            cand_valid <= 1'b1;
                            cand_x     <= unp_x;
                            cand_y     <= unp_y;
                            cand_size  <= unp_size;
                        end
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end

                if (frame_end) begin
                    valid <= 1'b1;
                    if (cand_valid) begin
                        x          <= cand_x;
                        y          <= cand_y;
                        size       <= cand_size;
                        blob_found <= 1'b1;
                    end else if (unp_ok) begin
                        x          <= unp_x;
                        y          <= unp_y;
                        size       <= unp_size;
                        blob_found <= 1'b1;
                    end else begin
                        blob_found <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_blob_decoder.sv
// Self-checking bench for ir_blob_decoder: table of full report frames plus
// hand-written abort, slow-byte, timeout and mid-frame reset sequences.
module tb_ir_blob_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic [9:0] x, y;
    logic [3:0] size;
    logic       blob_found, valid, error;

    int tests = 0;
    int fails = 0;
    int valid_seen = 0;
    int error_seen = 0;

    typedef logic [0:12][7:0] frame_t;

    typedef struct {
        frame_t bytes;
        int     ex;
        int     ey;
        int     es;
        int     ef;
    } vec_t;

    vec_t tbl[6];

    ir_blob_decoder #(
        .NUM_BLOBS      (4),
        .HEADER_BYTES   (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .data        (data),
        .data_valid  (data_valid),
        .x           (x),
        .y           (y),
        .size        (size),
        .blob_found  (blob_found),
        .valid       (valid),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid) valid_seen <= valid_seen + 1;
        if (error) error_seen <= error_seen + 1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where valid should be high.
    task automatic applyStimulus(input frame_t b, input logic coin, input int gap);
        frame_start = 1'b1;
        data_valid  = coin;
        data        = 8'hAA;
        @(negedge clk);
        frame_start = 1'b0;
        for (int k = 0; k < 13; k++) begin
            data       = b[k];
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            if (k < 12) for (int g = 0; g < gap; g++) @(negedge clk);
        end
    endtask

    task automatic sendBytes(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            data       = base + 8'(k);
            data_valid = 1'b1;
            @(negedge clk);
        end
        data_valid = 1'b0;
    endtask

    initial begin
        int v0, e0;

        tbl[0] = '{{8'h00, 8'h34, 8'h12, 8'h65, {9{8'hFF}}}, 564, 274, 5, 1};
        tbl[1] = '{{8'h00, {12{8'hFF}}}, 564, 274, 5, 0};
        tbl[2] = '{{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h20, 8'h00,
                    8'h50, 8'h60, 8'h00, 8'hFF, 8'hFF, 8'hFF}, 16, 32, 0, 1};
        tbl[3] = '{{8'h00, {9{8'hFF}}, 8'hAB, 8'hCD, 8'h9E}, 427, 717, 14, 1};
        tbl[4] = '{{8'h00, 8'hFF, 8'h00, 8'h30, 8'hFE, 8'h03, 8'h37, {6{8'hFF}}}, 1022, 3, 7, 1};
        tbl[5] = '{{8'h00, 8'h00, 8'hFF, 8'hC0, {9{8'hFF}}}, 1022, 3, 7, 0};

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_x", int'(x), 0);
        checkOutput("reset_y", int'(y), 0);
        checkOutput("reset_size", int'(size), 0);
        checkOutput("reset_found", int'(blob_found), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_error", int'(error), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v0 = valid_seen;
            applyStimulus(tbl[i].bytes, 1'b0, 0);
            checkOutput($sformatf("v%0d_valid", i), int'(valid), 1);
            checkOutput($sformatf("v%0d_x", i), int'(x), tbl[i].ex);
            checkOutput($sformatf("v%0d_y", i), int'(y), tbl[i].ey);
            checkOutput($sformatf("v%0d_size", i), int'(size), tbl[i].es);
            checkOutput($sformatf("v%0d_found", i), int'(blob_found), tbl[i].ef);
            @(negedge clk);
            checkOutput($sformatf("v%0d_valid_low", i), int'(valid), 0);
            checkOutput($sformatf("v%0d_valid_count", i), valid_seen - v0, 1);
        end

        // Abandoned frame, then a restart whose frame_start carries a byte.
        v0 = valid_seen;
        e0 = error_seen;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        data = 8'h00; data_valid = 1'b1; @(negedge clk);
        data = 8'h55; @(negedge clk);
        data = 8'h66; @(negedge clk);
        data = 8'h00; @(negedge clk);
        data = 8'h77; @(negedge clk);
        data_valid = 1'b0;
        applyStimulus({8'h00, 8'h01, 8'h02, 8'h00, {9{8'hFF}}}, 1'b1, 0);
        checkOutput("abort_valid", int'(valid), 1);
        checkOutput("abort_x", int'(x), 1);
        checkOutput("abort_y", int'(y), 2);
        checkOutput("abort_found", int'(blob_found), 1);
        @(negedge clk);
        checkOutput("abort_valid_count", valid_seen - v0, 1);
        checkOutput("abort_error_count", error_seen - e0, 0);

        // Gaps shorter than the timeout must not abort the frame.
        v0 = valid_seen;
        e0 = error_seen;
        applyStimulus(tbl[0].bytes, 1'b0, 12);
        checkOutput("slow_valid", int'(valid), 1);
        checkOutput("slow_x", int'(x), 564);
        checkOutput("slow_y", int'(y), 274);
        @(negedge clk);
        checkOutput("slow_error_count", error_seen - e0, 0);

        v0 = valid_seen;
        e0 = error_seen;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        sendBytes(4, 8'h10);
        for (int c = 0; c < 20; c++) @(negedge clk);
        checkOutput("timeout_error_count", error_seen - e0, 1);
        checkOutput("timeout_valid_count", valid_seen - v0, 0);
        checkOutput("timeout_x", int'(x), 564);
        checkOutput("timeout_y", int'(y), 274);
        checkOutput("timeout_size", int'(size), 5);
        checkOutput("timeout_found", int'(blob_found), 1);

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        sendBytes(3, 8'h20);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_x", int'(x), 0);
        checkOutput("midreset_y", int'(y), 0);
        checkOutput("midreset_size", int'(size), 0);
        checkOutput("midreset_found", int'(blob_found), 0);
        checkOutput("midreset_valid", int'(valid), 0);
        checkOutput("midreset_error", int'(error), 0);
        reset = 1'b0;
        @(negedge clk);

        v0 = valid_seen;
        applyStimulus(tbl[2].bytes, 1'b0, 0);
        checkOutput("post_reset_valid", int'(valid), 1);
        checkOutput("post_reset_x", int'(x), 16);
        checkOutput("post_reset_y", int'(y), 32);
        @(negedge clk);
        checkOutput("post_reset_valid_count", valid_seen - v0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
